reaction_delay_controller: RTL and testbench
============================================

// Module: reaction_delay_controller
// PURPOSE
//  Round sequencer for the reaction timer. Consumes the PRNG output. Converts it into a
//  random wait of MIN_DELAY_MS..MIN_DELAY_MS+2^RAND_BITS-1 ms. Lights the go LED, then
//  measures button reaction time in ms. Detects false starts and timeouts. Drives the
//  PRNG enable input and feeds reactionMs to the display stage.
// PARAMETERS
//  TICK_DIV      50000  clk cycles per 1 ms tick (50 MHz clock)
//  MIN_DELAY_MS  1000   fixed part of the random wait, in ms
//  RAND_BITS     12     number of randomNumber LSBs added to the wait (0..4095 ms)
//  MAX_REACT_MS  9999   reaction count at which the round times out
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous, active-low reset
//  start         in   1   one-cycle pulse: begin a round (debounced, synchronous)
//  button        in   1   debounced player button level, active high
//  randomNumber  in   16  value from the PRNG
//  randEnable    out  1   one-cycle pulse: advance the PRNG
//  ledGo         out  1   go LED, high while measuring
//  busy          out  1   high in ARM_REQ, ARM_LATCH, WAIT and GO
//  reactionMs    out  14  measured reaction time, in ms
//  resultValid   out  1   one-cycle pulse when a valid reaction completes
//  falseStart    out  1   sticky: button pressed before the LED came on
//  timeout       out  1   sticky: no press by MAX_REACT_MS
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE. All outputs are 0. reactionMs=0, prescaler=0, delay=0.
//  Button edge: btnRise = button & ~buttonQ, where buttonQ is button registered once.
//   A button that is held down never produces an event.
//  Prescaler: counts 0..TICK_DIV-1. tick is high on the cycle it wraps.
//   The prescaler clears to 0 on entry to WAIT and on entry to GO, so the first ms is full length.
//  FSM states:
//   IDLE: on start, go to ARM_REQ.
//   ARM_REQ (1 cycle): randEnable=1. Clear reactionMs, falseStart and timeout. Go to ARM_LATCH.
//   ARM_LATCH (1 cycle): randEnable=0.
//    Load delay = MIN_DELAY_MS + randomNumber[RAND_BITS-1:0], computed at 14-bit width with no overflow.
//    Go to WAIT.
//   WAIT:
//    btnRise -> falseStart=1, go to DONE. ledGo stays 0.
//    Otherwise, on tick: if delay==1, go to GO with ledGo=1 from the next cycle; else delay--.
//   GO: ledGo=1.
//    On btnRise: resultValid=1 for 1 cycle, reactionMs holds its value, ledGo=0, go to DONE.
//    Otherwise, on tick: reactionMs++.
//    If reactionMs reaches MAX_REACT_MS: timeout=1, ledGo=0, go to DONE.
//   DONE: hold reactionMs, falseStart and timeout. start -> ARM_REQ (new round).
//  Simultaneous events:
//   In GO, btnRise and tick on the same cycle: the press wins and reactionMs is not incremented.
//   In WAIT, btnRise and the final tick on the same cycle: false start wins.
//   start in ARM_REQ, ARM_LATCH, WAIT or GO is ignored.
//  Latency:
//   start to randEnable: 1 cycle.
//   btnRise registered to resultValid: same-edge update, i.e. 1 cycle after button rises.
//  Reset mid-round: immediate return to IDLE with all outputs 0. No partial result is kept.
// TESTING (bench overrides TICK_DIV=4, MIN_DELAY_MS=2, RAND_BITS=2)
//  1 Reset mid-GO: rst_n=0 -> ledGo=0, busy=0, reactionMs=0 asynchronously, before the next clk edge.
//  2 randomNumber=16'hFFF3, start pulse -> randEnable high exactly 1 cycle.
//    ledGo rises 5 ms (20 clk) after WAIT entry. Press after 3 ticks -> reactionMs=3, resultValid 1 cycle.
//  3 Press button during WAIT -> falseStart=1, ledGo never rises, state DONE, busy=0.
//  4 No press in GO with MAX_REACT_MS=5 -> timeout=1 when reactionMs=5, ledGo falls, resultValid stays 0.
//  5 Button held high from before start -> no false start.
//    Release and press in GO -> valid result. btnRise on a tick cycle -> count not incremented.
//  6 start pulses during WAIT -> ignored. start in DONE -> new round, flags cleared, new randEnable.

Source files
------------

// File: rtl/reaction_delay_controller.sv
// rtl/reaction_delay_controller.sv - reaction timer round sequencer: random wait, go LED, reaction measurement
module reaction_delay_controller #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 12,
  parameter int MAX_REACT_MS = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        button,
  input  logic [15:0] randomNumber,
  output logic        randEnable,
  output logic        ledGo,
  output logic        busy,
  output logic [13:0] reactionMs,
  output logic        resultValid,
  output logic        falseStart,
  output logic        timeout
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [13:0] MIN_DELAY = 14'(MIN_DELAY_MS);
  localparam logic [13:0] MAX_REACT = 14'(MAX_REACT_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM_REQ,
    S_ARM_LATCH,
    S_WAIT,
    S_GO,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            button_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [13:0]     delay_q, delay_d;
  logic [13:0]     react_q, react_d;
  logic            rand_en_q, rand_en_d;
  logic            led_go_q, led_go_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            false_start_q, false_start_d;
  logic            timeout_q, timeout_d;

  logic            btn_rise;
  logic            tick;
  logic [13:0]     react_inc;
  logic [13:0]     rand_ext;
  logic            unused_rand_hi;

  // Only the low RAND_BITS of the PRNG word contribute to the wait.
  assign rand_ext       = 14'(randomNumber[RAND_BITS-1:0]);
  assign unused_rand_hi = ^randomNumber[15:RAND_BITS];

  assign btn_rise  = button & ~button_q;
  assign tick      = (presc_q == PRESC_MAX);
  assign react_inc = react_q + 14'd1;

  // Next-state and next-output logic; the prescaler only runs in WAIT and GO.
  always_comb begin
    state_d       = state_q;
    presc_d       = '0;
    delay_d       = delay_q;
    react_d       = react_q;
    rand_en_d     = 1'b0;
    led_go_d      = led_go_q;
    valid_d       = 1'b0;
    false_start_d = false_start_q;
    timeout_d     = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_ARM_REQ;
          rand_en_d     = 1'b1;
          react_d       = '0;
          false_start_d = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      S_ARM_REQ: begin
        state_d = S_ARM_LATCH;
      end
      S_ARM_LATCH: begin
        delay_d = MIN_DELAY + rand_ext;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (btn_rise) begin
          // An early press beats the final tick of the wait.
          false_start_d = 1'b1;
          state_d       = S_DONE;
        end else if (tick) begin
          if (delay_q == 14'd1) begin
            state_d  = S_GO;
            led_go_d = 1'b1;
            presc_d  = '0;
          end else begin
            delay_d = delay_q - 14'd1;
          end
        end
      end
      S_GO: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (btn_rise) begin
          // The press wins over a coincident tick, so the count is not bumped.
          valid_d  = 1'b1;
          led_go_d = 1'b0;
          state_d  = S_DONE;
        end else if (tick) begin
          react_d = react_inc;
          if (react_inc == MAX_REACT) begin
            timeout_d = 1'b1;
            led_go_d  = 1'b0;
            state_d   = S_DONE;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        led_go_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_ARM_REQ) || (state_d == S_ARM_LATCH) ||
             (state_d == S_WAIT)    || (state_d == S_GO);
  end

  // State and registered outputs; reset drops everything to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      button_q      <= 1'b0;
      presc_q       <= '0;
      delay_q       <= '0;
      react_q       <= '0;
      rand_en_q     <= 1'b0;
      led_go_q      <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      button_q      <= button;
      presc_q       <= presc_d;
      delay_q       <= delay_d;
      react_q       <= react_d;
      rand_en_q     <= rand_en_d;
      led_go_q      <= led_go_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      false_start_q <= false_start_d;
      timeout_q     <= timeout_d;
    end
  end

  assign randEnable  = rand_en_q;
  assign ledGo       = led_go_q;
  assign busy        = busy_q;
  assign reactionMs  = react_q;
  assign resultValid = valid_q;
  assign falseStart  = false_start_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_reaction_delay_controller.sv
// tb/tb_reaction_delay_controller.sv - directed table-driven bench for reaction_delay_controller
module tb_reaction_delay_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        button;
  logic [15:0] randomNumber;
  logic        randEnable;
  logic        ledGo;
  logic        busy;
  logic [13:0] reactionMs;
  logic        resultValid;
  logic        falseStart;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  reaction_delay_controller #(
    .TICK_DIV(4),
    .MIN_DELAY_MS(2),
    .RAND_BITS(2),
    .MAX_REACT_MS(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .button(button),
    .randomNumber(randomNumber),
    .randEnable(randEnable),
    .ledGo(ledGo),
    .busy(busy),
    .reactionMs(reactionMs),
    .resultValid(resultValid),
    .falseStart(falseStart),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One round per record. fs_k >= 0: press during WAIT, k cycles after WAIT entry.
  // press_j >= 0: press in GO, j cycles after ledGo rises. Both < 0: let it time out.
  typedef struct {
    logic [15:0] rnd;
    int          fs_k;
    int          press_j;
    int          exp_delay;
    int          exp_react;
    logic        exp_valid;
    logic        exp_fs;
    logic        exp_to;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issue a start from DONE/IDLE and walk through ARM_REQ/ARM_LATCH; returns at WAIT entry + half cycle.
  task automatic arm(input logic [15:0] rnd);
    start = 1'b1;
    randomNumber = rnd;
    @(negedge clk);
    start = 1'b0;
    chk("rand_en_pulse", randEnable, 1);
    chk("busy_arm", busy, 1);
    chk("react_cleared", reactionMs, 0);
    chk("fs_cleared", falseStart, 0);
    chk("to_cleared", timeout, 0);
    @(negedge clk);
    chk("rand_en_one_cycle", randEnable, 0);
    @(negedge clk);
  endtask

  // Count cycles from WAIT entry until ledGo rises, bounded.
  task automatic wait_go(output int k);
    k = 0;
    while (!ledGo && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_row(input vec_t v);
    int   k;
    int   j;
    logic seen;
    arm(v.rnd);
    if (v.fs_k >= 0) begin
      k = 0;
      seen = 1'b0;
      while (k < v.fs_k) begin
        if (ledGo) seen = 1'b1;
        @(negedge clk);
        k++;
      end
      button = 1'b1;
      @(negedge clk);
      button = 1'b0;
      if (ledGo) seen = 1'b1;
      chk("fs_led_never", seen, 0);
    end else begin
      wait_go(k);
      chk("go_delay_clk", k, 4 * v.exp_delay);
      j = 0;
      if (v.press_j >= 0) begin
        while (j < v.press_j) begin
          @(negedge clk);
          j++;
        end
        chk("led_before_press", ledGo, 1);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
      end else begin
        seen = 1'b0;
        while (!timeout && j < 100) begin
          if (resultValid) seen = 1'b1;
          @(negedge clk);
          j++;
        end
        chk("timeout_clk", j, 20);
        chk("to_no_valid", seen, 0);
      end
    end
    chk("out_valid", resultValid, v.exp_valid);
    chk("out_react", reactionMs, v.exp_react);
    chk("out_fs", falseStart, v.exp_fs);
    chk("out_to", timeout, v.exp_to);
    chk("out_led", ledGo, 0);
    chk("out_busy", busy, 0);
    @(negedge clk);
    chk("valid_one_cycle", resultValid, 0);
    chk("react_hold", reactionMs, v.exp_react);
    chk("led_stays_off", ledGo, 0);
  endtask

  initial begin
    int k;
    int j;

    vecs[0] = '{16'hFFF3, -1, 12, 5, 3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, -1,  0, 2, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0001, -1, 15, 3, 3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h0002, -1, 19, 4, 4, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h1236, -1, -1, 4, 5, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'hABCD,  5, -1, 3, 0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h0003, 19, -1, 5, 0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h0000,  0, -1, 2, 0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    button = 1'b0;
    randomNumber = 16'h0000;
    #3;
    chk("rst_rand_en", randEnable, 0);
    chk("rst_led", ledGo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_react", reactionMs, 0);
    chk("rst_valid", resultValid, 0);
    chk("rst_fs", falseStart, 0);
    chk("rst_to", timeout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      run_row(vecs[i]);
    end

    // Button held from before start: no false start; release and re-press on a tick edge.
    button = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arm(16'h0000);
    wait_go(k);
    chk("held_go_delay", k, 8);
    chk("held_no_fs", falseStart, 0);
    j = 0;
    while (j < 7) begin
      @(negedge clk);
      j++;
      if (j == 2) button = 1'b0;
    end
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    chk("held_valid", resultValid, 1);
    chk("held_react_tick_edge", reactionMs, 1);
    chk("held_fs", falseStart, 0);
    @(negedge clk);

    // start pulses in WAIT and GO are ignored.
    arm(16'h0000);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_wait_rand", randEnable, 0);
    chk("start_in_wait_busy", busy, 1);
    k = 3;
    while (!ledGo && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("start_in_wait_delay", k, 8);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_go_rand", randEnable, 0);
    chk("start_in_go_led", ledGo, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    chk("start_ign_valid", resultValid, 1);
    chk("start_ign_react", reactionMs, 1);
    @(negedge clk);

    // Reset in the middle of GO clears outputs without waiting for a clock edge.
    arm(16'h0000);
    wait_go(k);
    for (int n = 0; n < 9; n++) @(negedge clk);
    chk("pre_reset_react", reactionMs, 2);
    chk("pre_reset_led", ledGo, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", ledGo, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_react", reactionMs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_led", ledGo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
